// File: rtl/sap2_mem_responder.sv
// SAP-II memory responder: services MAR/MDR read/write requests with programmable
// wait states; low addresses are write-protected ROM, the rest is RAM.
//
// state  | meaning
// S_IDLE | waiting for a request; busy low
// S_BUSY | counting down wait states; requests ignored
// S_DONE | one cycle: ready/err valid, read data loaded, write committed
module sap2_mem_responder #(
    parameter int MEM_AW      = 12,
    parameter int ROM_TOP     = 'h7FF,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rd_req,
    input  logic        wr_req,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int              DEPTH    = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] ROM_LAST = MEM_AW'(ROM_TOP);
    localparam logic [3:0]      WS       = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [MEM_AW-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              wr_q;
    logic              conflict_q;
    logic [3:0]        cnt_q;

    // Contents survive CLR; only power-up (simulation start) clears them.
    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    logic              req_one;
    logic              req_both;
    logic              prot_hit;
    logic              rd_load;
    logic              mem_we;
    logic [MEM_AW-1:0] rd_addr;

    assign req_one  = rd_req ^ wr_req;
    assign req_both = rd_req & wr_req;
    assign prot_hit = (addr_q <= ROM_LAST);
    assign busy     = (state != S_IDLE);

    // rdata is loaded on the edge entering S_DONE so it is valid alongside ready.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        err       = 1'b0;
        rd_load   = 1'b0;
        mem_we    = 1'b0;
        rd_addr   = addr_q;
        case (state)
            S_IDLE: begin
                rd_addr = addr[MEM_AW-1:0];
                if (req_both) begin
                    state_nxt = S_DONE;
                end else if (req_one) begin
                    state_nxt = (WS == 4'd0) ? S_DONE : S_BUSY;
                    rd_load   = rd_req && (WS == 4'd0);
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_nxt = S_DONE;
                    rd_load   = !wr_q;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                ready     = 1'b1;
                err       = conflict_q | (wr_q & prot_hit);
                mem_we    = wr_q & !conflict_q & !prot_hit;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state      <= S_IDLE;
            rdata      <= 8'h00;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && (req_one || req_both)) begin
                addr_q     <= addr[MEM_AW-1:0];
                wdata_q    <= wdata;
                wr_q       <= wr_req & ~rd_req;
                conflict_q <= req_both;
                cnt_q      <= WS;
            end else if (state == S_BUSY) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (rd_load) begin
                rdata <= mem[rd_addr];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR && mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_sap2_mem_responder.sv
// Directed bench for sap2_mem_responder: one instance with two wait states,
// one with none for the back-to-back checks.
module tb_sap2_mem_responder;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [15:0] addr, addr0;
    logic [7:0]  wdata, wdata0;
    logic        rd_req, wr_req, rd_req0, wr_req0;
    logic [7:0]  rdata, rdata0;
    logic        ready, err, busy, ready0, err0, busy0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    sap2_mem_responder #(.MEM_AW(12), .ROM_TOP('h7FF), .WAIT_STATES(2)) dut (
        .CLK(CLK), .CLR(CLR), .addr(addr), .wdata(wdata), .rd_req(rd_req),
        .wr_req(wr_req), .rdata(rdata), .ready(ready), .err(err), .busy(busy)
    );

    sap2_mem_responder #(.MEM_AW(12), .ROM_TOP('h7FF), .WAIT_STATES(0)) dut0 (
        .CLK(CLK), .CLR(CLR), .addr(addr0), .wdata(wdata0), .rd_req(rd_req0),
        .wr_req(wr_req0), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One access on the WAIT_STATES=2 instance. lat counts cycles after the
    // accepting edge until ready is seen (1 = the cycle right after it).
    task automatic acc(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [7:0] d, output int lat, output logic e,
                       output logic [7:0] rd_out);
        rd_req = rd; wr_req = wr; addr = a; wdata = d;
        step();
        rd_req = 1'b0; wr_req = 1'b0; addr = 16'hFFFF; wdata = 8'h00;
        lat = 0; e = 1'bx; rd_out = 8'hxx;
        for (int i = 1; i <= 10; i++) begin
            if (ready) begin
                lat = i; e = err; rd_out = rdata;
                break;
            end
            step();
        end
        step();
        chk("ready_one_cycle", {15'b0, ready}, 16'd0);
    endtask

    int         lat;
    logic       e;
    logic [7:0] d;
    int         pulses;

    initial begin
        CLR = 1'b1; addr = 0; wdata = 0; rd_req = 0; wr_req = 0;
        addr0 = 0; wdata0 = 0; rd_req0 = 0; wr_req0 = 0;

        // 1: reset then idle
        step(); step();
        CLR = 1'b0;
        chk("rst_rdata", {8'h0, rdata}, 16'h00);
        chk("rst_ready", {15'b0, ready}, 16'd0);
        chk("rst_busy",  {15'b0, busy}, 16'd0);
        chk("rst_err",   {15'b0, err}, 16'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ready) pulses++;
        end
        chk("idle_no_ready", 16'(pulses), 16'd0);

        // 2: RAM write then read
        acc(1'b0, 1'b1, 16'h0900, 8'hA5, lat, e, d);
        chk("ram_wr_lat", 16'(lat), 16'd3);
        chk("ram_wr_err", {15'b0, e}, 16'd0);
        acc(1'b1, 1'b0, 16'h0900, 8'h00, lat, e, d);
        chk("ram_rd_lat",  16'(lat), 16'd3);
        chk("ram_rd_err",  {15'b0, e}, 16'd0);
        chk("ram_rd_data", {8'h0, d}, 16'h00A5);
        chk("ram_rd_hold", {8'h0, rdata}, 16'h00A5);

        // 3: ROM protection
        dut.mem[12'h010] = 8'h3C;
        acc(1'b0, 1'b1, 16'h0010, 8'hFF, lat, e, d);
        chk("rom_wr_lat", 16'(lat), 16'd3);
        chk("rom_wr_err", {15'b0, e}, 16'd1);
        acc(1'b1, 1'b0, 16'h0010, 8'h00, lat, e, d);
        chk("rom_rd_data", {8'h0, d}, 16'h003C);
        chk("rom_rd_err",  {15'b0, e}, 16'd0);

        // 4: conflict, then mirrored read
        acc(1'b1, 1'b1, 16'h0900, 8'h00, lat, e, d);
        chk("conf_lat",   16'(lat), 16'd1);
        chk("conf_err",   {15'b0, e}, 16'd1);
        chk("conf_rdata", {8'h0, d}, 16'h003C);
        acc(1'b1, 1'b0, 16'hF900, 8'h00, lat, e, d);
        chk("mirror_data", {8'h0, d}, 16'h00A5);
        chk("mirror_lat",  16'(lat), 16'd3);

        // 5: reset in the first BUSY cycle aborts the write
        wr_req = 1'b1; addr = 16'h0A00; wdata = 8'h5A;
        step();
        wr_req = 1'b0;
        chk("abort_busy", {15'b0, busy}, 16'd1);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("abort_idle",  {15'b0, busy}, 16'd0);
        chk("abort_rdata", {8'h0, rdata}, 16'h00);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (ready) pulses++;
            step();
        end
        chk("abort_no_ready", 16'(pulses), 16'd0);
        acc(1'b1, 1'b0, 16'h0A00, 8'h00, lat, e, d);
        chk("abort_mem", {8'h0, d}, 16'h0000);

        // 6: WAIT_STATES=0, rd_req held across two addresses
        dut0.mem[12'h900] = 8'hA5;
        dut0.mem[12'h901] = 8'hC3;
        rd_req0 = 1'b1; addr0 = 16'h0900;
        step();
        chk("b2b_ready1", {15'b0, ready0}, 16'd1);
        chk("b2b_data1",  {8'h0, rdata0}, 16'h00A5);
        chk("b2b_err1",   {15'b0, err0}, 16'd0);
        addr0 = 16'h0901;
        step();
        chk("b2b_gap_ready", {15'b0, ready0}, 16'd0);
        chk("b2b_gap_busy",  {15'b0, busy0}, 16'd0);
        chk("b2b_gap_data",  {8'h0, rdata0}, 16'h00A5);
        step();
        chk("b2b_ready2", {15'b0, ready0}, 16'd1);
        chk("b2b_data2",  {8'h0, rdata0}, 16'h00C3);
        rd_req0 = 1'b0; addr0 = 16'h0900;
        step();
        chk("b2b_end_ready", {15'b0, ready0}, 16'd0);
        step();
        chk("b2b_end_idle", {15'b0, ready0 | busy0}, 16'd0);
        chk("b2b_end_data", {8'h0, rdata0}, 16'h00C3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
